// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan family: hex glyph table, DP bit
// position and slot-length helper.
package seg_pkg;

  localparam int DP_BIT = 7;

  // Entry i is the {dp=0,g..a} pattern for hex digit i (index 15 is the MSB element).
  localparam logic [15:0][7:0] HEX7_TBL = {
    8'h71, 8'h79, 8'h5e, 8'h39, 8'h7c, 8'h77, 8'h6f, 8'h7f,
    8'h07, 8'h7d, 8'h6d, 8'h66, 8'h4f, 8'h5b, 8'h06, 8'h3f
  };

  function automatic int slot_len(input int blank_cyc, input int bright_w);
    return blank_cyc + (1 << bright_w);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-data registers to scanner, and scanner to board pins.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 4
);
  logic [4*N_DIGITS-1:0] seg_data;
  logic [N_DIGITS-1:0]   seg_on;
  logic [N_DIGITS-1:0]   dp_on;
  logic [N_DIGITS-1:0]   blink;
  logic [BRIGHT_W-1:0]   brightness;
  logic [7:0]            seg_led;
  logic [N_DIGITS-1:0]   cat;

  modport master (output seg_data, seg_on, dp_on, blink, brightness,
                  input  seg_led, cat);
  modport slave  (input  seg_data, seg_on, dp_on, blink, brightness,
                  output seg_led, cat);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to {dp,g,f,e,d,c,b,a} glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] pat
);
  always_comb begin
    pat         = HEX7_TBL[nib];
    pat[DP_BIT] = dp;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-slot snapshot, anti-ghost blanking,
// PWM brightness window, per-digit blink, output polarity.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int BLANK_CYC      = 2,
  parameter int BRIGHT_W       = 4,
  parameter int BLINK_DIV_W    = 24,
  parameter bit CAT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);
  localparam int L     = slot_len(BLANK_CYC, BRIGHT_W);
  localparam int PH_W  = $clog2(L);
  localparam int DIG_W = $clog2(N_DIGITS);

  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(L - 1);
  localparam logic [PH_W-1:0]     PH_BLANK = PH_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] CAT_OFF  = {N_DIGITS{CAT_ACTIVE_LOW}};
  localparam logic [7:0]          SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  logic [PH_W-1:0]           ph, ph_off;
  logic [DIG_W-1:0]          dig;
  logic [BLINK_DIV_W-1:0]    bl_cnt;
  logic [3:0]                snap_nib;
  logic                      snap_on, snap_dp, snap_blink;
  logic [BRIGHT_W-1:0]       snap_bright;
  logic [N_DIGITS-1:0][3:0]  nibs;
  logic [N_DIGITS-1:0]       sel;
  logic [7:0]                pat;
  logic                      lit;

  assign nibs   = bus.seg_data;
  assign ph_off = ph - PH_BLANK;
  assign sel    = N_DIGITS'(1) << dig;

  // Blanking is always >= 1 clock, so L > 2^BRIGHT_W and PH_W >= BRIGHT_W+1:
  // the window offset fits the widened compare without truncation.
  assign lit = (ph >= PH_BLANK)
            && ((BRIGHT_W+1)'(ph_off) < {1'b0, snap_bright})
            && snap_on
            && !(snap_blink && bl_cnt[BLINK_DIV_W-1]);

  seg_hex_decode u_dec (.nib(snap_nib), .dp(snap_dp), .pat(pat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= '0;
      dig         <= '0;
      bl_cnt      <= '0;
      snap_nib    <= '0;
      snap_on     <= 1'b0;
      snap_dp     <= 1'b0;
      snap_blink  <= 1'b0;
      snap_bright <= '0;
      bus.cat     <= CAT_OFF;
      bus.seg_led <= SEG_OFF;
    end else begin
      bl_cnt <= bl_cnt + 1'b1;
      if (ph == PH_LAST) begin
        ph  <= '0;
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end else begin
        ph  <= ph + 1'b1;
      end
      // Slot contents are frozen at slot start; later input changes wait for the next visit.
      if (ph == '0) begin
        snap_nib    <= nibs[dig];
        snap_on     <= bus.seg_on[dig];
        snap_dp     <= bus.dp_on[dig];
        snap_blink  <= bus.blink[dig];
        snap_bright <= bus.brightness;
      end
      bus.cat     <= lit ? (sel ^ CAT_OFF) : CAT_OFF;
      bus.seg_led <= lit ? (pat ^ SEG_OFF) : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: slot-level reference model feeds an
// expectation queue drained by an independent output monitor.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int BLANK = 2;
  localparam int BW    = 2;
  localparam int BDW   = 6;
  localparam int L     = BLANK + (1 << BW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus();

  seg_scan_ctrl #(
    .N_DIGITS(N), .BLANK_CYC(BLANK), .BRIGHT_W(BW), .BLINK_DIV_W(BDW),
    .CAT_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  logic [7:0] hexref [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                              8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: k counts clock edges since reset release.
  int   k = 0;
  logic [3:0] s_nib = '0;
  logic s_on = 0, s_dp = 0, s_bl = 0;
  int   s_br = 0;

  always @(posedge clk) begin
    int  m_ph, m_d;
    bit  lit, blink_off;
    if (!rst_n) begin
      k = 0; s_nib = '0; s_on = 0; s_dp = 0; s_bl = 0; s_br = 0;
      exp_q.push_back({4'hF, 8'h00});
    end else begin
      m_ph      = k % L;
      m_d       = (k / L) % N;
      blink_off = (k % 64) >= 32;
      lit = (m_ph >= BLANK) && ((m_ph - BLANK) < s_br) && s_on && !(s_bl && blink_off);
      if (lit) exp_q.push_back({~(4'b0001 << m_d), s_dp, hexref[s_nib][6:0]});
      else     exp_q.push_back({4'hF, 8'h00});
      if (m_ph == 0) begin
        s_nib = bus.seg_data[4*m_d +: 4];
        s_on  = bus.seg_on[m_d];
        s_dp  = bus.dp_on[m_d];
        s_bl  = bus.blink[m_d];
        s_br  = int'(bus.brightness);
      end
      k++;
    end
  end

  // Monitor: outputs are sampled mid-cycle; while reset is held they must be inactive.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = {4'hF, 8'h00};
      chk(rst_n ? "scan" : "reset_out", {bus.cat, bus.seg_led}, e);
      chk("one_hot", {11'b0, ($countones(~bus.cat) <= 1)}, 12'd1);
      if (bus.cat == 4'hF) chk("dark_seg", {4'h0, bus.seg_led}, 12'h000);
    end
  end

  task automatic wait_ph(input int p, input int d);
    int n = 0;
    while (!((k % L) == p && (d < 0 || ((k / L) % N) == d)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_ph: got timeout expected ph=%0d dig=%0d", p, d);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {bus.cat, bus.seg_led}, {4'hF, 8'h00});
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.seg_data   = 16'h3210;
    bus.seg_on     = 4'hF;
    bus.dp_on      = 4'h0;
    bus.blink      = 4'h0;
    bus.brightness = 2'd3;
    repeat (3) @(negedge clk);
    chk("reset_hold", {bus.cat, bus.seg_led}, {4'hF, 8'h00});
    #1 rst_n = 1'b1;

    repeat (2*N*L) @(negedge clk);
    bus.brightness = 2'd0;
    repeat (30) @(negedge clk);
    bus.brightness = 2'd1; bus.dp_on = 4'b0010;
    repeat (30) @(negedge clk);
    bus.brightness = 2'd3; bus.dp_on = 4'b0000; bus.seg_on = 4'b0101;
    repeat (30) @(negedge clk);
    bus.seg_on = 4'hF; bus.blink = 4'b0001;
    repeat (140) @(negedge clk);
    bus.blink = 4'b0000;

    wait_ph(3, 0);
    bus.seg_data = 16'h3298;
    repeat (2*N*L) @(negedge clk);

    wait_ph(4, -1);
    pulse_reset();
    repeat (2*N*L) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        #1;
        bus.seg_data   = 16'($urandom);
        bus.seg_on     = 4'($urandom_range(0, 15));
        bus.dp_on      = 4'($urandom_range(0, 15));
        bus.blink      = 4'($urandom_range(0, 15));
        bus.brightness = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 249) == 0) pulse_reset();
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
